ifu_prefetch: RTL and testbench

- Next-generation instruction fetch unit. Keeps up to MAX_OUTSTANDING fetch requests in flight on the inst SRAM-like bus.
- Returned instructions, with their PC and exception fields, go into a QUEUE_DEPTH-entry FIFO that feeds ID.
- Sits between the global redirect sources (WB flush, ID branch) and ID. Address translation is delegated to an external MMU port, which returns results combinationally.

---
 rtl/ifu_prefetch.sv | 139 +++++++++++++
 tb/tb_ifu_prefetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetcher with bounded outstanding bus requests and an IF->ID queue.
// Optional macro IFU_BYPASS_EN forwards a response straight to ID when the queue is empty.
module ifu_prefetch #(
   parameter int unsigned  QUEUE_DEPTH     = 4,
   parameter int unsigned  MAX_OUTSTANDING = 2,
   parameter logic [31:0]  RESET_PC        = 32'h1c00_0000,
   localparam int unsigned IF2ID_LEN       = 81
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic [31:0]          flush_target,
   input  logic                 br_taken,
   input  logic [31:0]          br_target,
   input  logic                 br_stall,
   input  logic                 id_allowin,
   output logic                 inst_sram_req,
   output logic                 inst_sram_wr,
   output logic [1:0]           inst_sram_size,
   output logic [31:0]          inst_sram_addr,
   output logic [3:0]           inst_sram_wstrb,
   output logic [31:0]          inst_sram_wdata,
   input  logic                 inst_sram_addr_ok,
   input  logic                 inst_sram_data_ok,
   input  logic [31:0]          inst_sram_rdata,
   output logic [31:0]          mmu_vaddr,
   input  logic [31:0]          mmu_paddr,
   input  logic                 mmu_ex,
   input  logic [5:0]           mmu_ecode,
   output logic                 if_to_id_valid,
   output logic [IF2ID_LEN-1:0] if_to_id_zip
);
   localparam int unsigned QW  = $clog2(QUEUE_DEPTH);
   localparam int unsigned CW  = QW + 1;
   localparam int unsigned OW  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [31:0] NOP = 32'h0280_0000;

   logic [IF2ID_LEN-1:0] q_mem [QUEUE_DEPTH];
   logic [QW-1:0]        q_rd, q_wr;
   logic [CW-1:0]        q_cnt;
   logic [31:0]          pc_mem [MAX_OUTSTANDING];
   logic [PW-1:0]        pc_rd, pc_wr;
   logic [OW-1:0]        outstanding, outstanding_next, discard;
   logic [31:0]          fetch_pc;
   logic                 ex_pending;

   logic                 id_ready, redirect, issue, resp_keep, ex_push, push, pop;
   logic                 q_empty, q_full;
   logic [31:0]          target;
   logic [IF2ID_LEN-1:0] resp_entry, ex_entry, push_data;
`ifdef IFU_BYPASS_EN
   logic                 bypass;
`endif

   function automatic logic [PW-1:0] pc_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = '0;
   assign inst_sram_wdata = '0;
   assign inst_sram_addr  = mmu_paddr;
   assign mmu_vaddr       = fetch_pc;

   always_comb begin
      id_ready = id_allowin & ~br_stall;
      redirect = flush | br_taken;
      target   = flush ? flush_target : br_target;
      q_empty  = (q_cnt == '0);
      q_full   = (q_cnt == CW'(QUEUE_DEPTH));
      // Counting in-flight requests against the queue keeps a slot reserved for every response.
      inst_sram_req = resetn & ~redirect & ~ex_pending & ~mmu_ex
                    & (outstanding < OW'(MAX_OUTSTANDING))
                    & ((32'(outstanding) + 32'(q_cnt)) < QUEUE_DEPTH);
      issue            = inst_sram_req & inst_sram_addr_ok;
      outstanding_next = outstanding + OW'(issue) - OW'(inst_sram_data_ok);
      resp_entry = {inst_sram_rdata, pc_mem[pc_rd], 17'b0};
      ex_entry   = {NOP, fetch_pc, 1'b1, mmu_ecode, 9'b0, 1'b0};
      resp_keep  = inst_sram_data_ok & (discard == '0) & ~redirect;
      ex_push    = mmu_ex & ~ex_pending & (outstanding == '0) & ~q_full & ~redirect;
      push_data  = resp_keep ? resp_entry : ex_entry;
`ifdef IFU_BYPASS_EN
      bypass         = resetn & resp_keep & q_empty;
      push           = (resp_keep & ~(bypass & id_ready)) | ex_push;
      pop            = ~q_empty & ~redirect & id_ready;
      if_to_id_valid = (~q_empty & ~redirect) | bypass;
      if_to_id_zip   = bypass ? resp_entry : q_mem[q_rd];
`else
      push           = resp_keep | ex_push;
      pop            = ~q_empty & ~redirect & id_ready;
      if_to_id_valid = ~q_empty & ~redirect;
      if_to_id_zip   = q_mem[q_rd];
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc    <= RESET_PC;
         ex_pending  <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         q_rd        <= '0;
         q_wr        <= '0;
         q_cnt       <= '0;
         pc_rd       <= '0;
         pc_wr       <= '0;
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_mem[QW'(i)] <= '0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) pc_mem[PW'(i)] <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (issue) begin
            pc_mem[pc_wr] <= fetch_pc;
            pc_wr         <= pc_inc(pc_wr);
         end
         // The PC FIFO keeps draining across redirects so cancelled responses stay aligned.
         if (inst_sram_data_ok) pc_rd <= pc_inc(pc_rd);
         if (redirect) begin
            fetch_pc   <= target;
            ex_pending <= 1'b0;
            discard    <= outstanding_next;
            q_rd       <= '0;
            q_wr       <= '0;
            q_cnt      <= '0;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (ex_push) ex_pending <= 1'b1;
            if (inst_sram_data_ok && discard != '0) discard <= discard - 1'b1;
            if (push) begin
               q_mem[q_wr] <= push_data;
               q_wr        <= q_wr + 1'b1;
            end
            if (pop) q_rd <= q_rd + 1'b1;
            q_cnt <= q_cnt + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: streaming, backpressure, redirects, MMU exception, async reset.
module tb_ifu_prefetch;
   typedef logic [80:0] val_t;

   logic        clk, resetn, flush, br_taken, br_stall, id_allowin;
   logic [31:0] flush_target, br_target;
   logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] mmu_vaddr, mmu_paddr;
   logic        mmu_ex;
   logic [5:0]  mmu_ecode;
   logic        if_to_id_valid;
   logic [80:0] if_to_id_zip;

   logic        ex_en;
   logic [31:0] ex_pc;
   assign mmu_paddr = {4'h0, mmu_vaddr[27:0]};
   assign mmu_ex    = ex_en & (mmu_vaddr == ex_pc);
   assign mmu_ecode = 6'h3f;

   ifu_prefetch #(.QUEUE_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h1c00_0000)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .flush_target(flush_target),
      .br_taken(br_taken), .br_target(br_target), .br_stall(br_stall), .id_allowin(id_allowin),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .mmu_vaddr(mmu_vaddr), .mmu_paddr(mmu_paddr), .mmu_ex(mmu_ex), .mmu_ecode(mmu_ecode),
      .if_to_id_valid(if_to_id_valid), .if_to_id_zip(if_to_id_zip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0;
   int          cyc = 0, max_out = 0;
   bit          mem_hold = 1'b0;
   bit          s_req, s_valid;
   logic [31:0] mem_q[$];
   logic [31:0] iss_q[$];
   val_t        pop_q[$];
   int          pop_cyc[$];

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      return {4'h0, pc[27:0]} ^ 32'h5a5a_5a5a;
   endfunction
   function automatic logic [31:0] zinst(input val_t z); return z[80:49]; endfunction
   function automatic logic [31:0] zpc(input val_t z);   return z[48:17]; endfunction
   function automatic logic [16:0] zex(input val_t z);   return z[16:0];  endfunction

   // One bus cycle: memory answers oldest accepted request (1-cycle latency), sample at negedge.
   task automatic tick();
      if (!mem_hold && mem_q.size() > 0) begin
         inst_sram_data_ok = 1'b1;
         inst_sram_rdata   = mem_q.pop_front() ^ 32'h5a5a_5a5a;
      end else begin
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = '0;
      end
      @(negedge clk);
      s_req   = inst_sram_req;
      s_valid = if_to_id_valid;
      if (inst_sram_req && inst_sram_addr_ok) begin
         mem_q.push_back(inst_sram_addr);
         iss_q.push_back(mmu_vaddr);
      end
      if (if_to_id_valid && id_allowin && !br_stall) begin
         pop_q.push_back(if_to_id_zip);
         pop_cyc.push_back(cyc);
      end
      if (mem_q.size() > max_out) max_out = mem_q.size();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_pops(input int n, input int budget);
      for (int k = 0; k < budget && pop_q.size() < n; k++) tick();
      check("pops_avail", val_t'(pop_q.size() >= n), val_t'(1));
   endtask

   task automatic do_reset();
      resetn = 1'b0; flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0; mem_hold = 1'b0;
      mem_q.delete(); iss_q.delete(); pop_q.delete(); pop_cyc.delete(); max_out = 0;
      repeat (2) tick();
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b1; flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0; id_allowin = 1'b1;
      flush_target = '0; br_target = '0; inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0;
      inst_sram_rdata = '0; ex_en = 1'b0; ex_pc = '0;
      #1 resetn = 1'b0;
      #1;
      check("rst_req",   val_t'(inst_sram_req),   val_t'(0));
      check("rst_valid", val_t'(if_to_id_valid),  val_t'(0));
      check("rst_zip",   val_t'(if_to_id_zip),    val_t'(0));
      check("tie_wr",    val_t'(inst_sram_wr),    val_t'(0));
      check("tie_size",  val_t'(inst_sram_size),  val_t'(2));
      check("tie_wstrb", val_t'(inst_sram_wstrb), val_t'(0));
      check("tie_wdata", val_t'(inst_sram_wdata), val_t'(0));
      check("rst_vaddr", val_t'(mmu_vaddr),       val_t'(32'h1c00_0000));

      // Streaming with ID always ready
      do_reset();
      run_pops(3, 20);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] e;
         e = 32'h1c00_0000 + 32'(4 * i);
         if (pop_q.size() > i) begin
            check("t1_pc",   val_t'(zpc(pop_q[i])),   val_t'(e));
            check("t1_inst", val_t'(zinst(pop_q[i])), val_t'(exp_inst(e)));
            check("t1_ex",   val_t'(zex(pop_q[i])),   val_t'(0));
         end
      end
      check("t1_maxout", val_t'(max_out <= 2), val_t'(1));
      begin
         int n0;
         br_stall = 1'b1;
         n0 = pop_q.size();
         repeat (4) tick();
         check("t1_stall_nopop", val_t'(pop_q.size()), val_t'(n0));
         check("t1_stall_valid", val_t'(s_valid), val_t'(1));
         br_stall = 1'b0;
         run_pops(n0 + 2, 20);
         if (pop_q.size() > n0)
            check("t1_stall_seq", val_t'(zpc(pop_q[n0])), val_t'(zpc(pop_q[n0 - 1]) + 32'd4));
      end

      // ID blocked: queue fills to depth, then drains back to back
      id_allowin = 1'b0;
      do_reset();
      repeat (20) tick();
      check("t2_req",     val_t'(s_req),         val_t'(0));
      check("t2_outst",   val_t'(mem_q.size()),  val_t'(0));
      check("t2_issued",  val_t'(iss_q.size()),  val_t'(4));
      check("t2_nopop",   val_t'(pop_q.size()),  val_t'(0));
      begin
         int r;
         r = cyc;
         id_allowin = 1'b1;
         run_pops(5, 20);
         for (int i = 0; i < 5; i++)
            if (pop_q.size() > i)
               check("t2_pc", val_t'(zpc(pop_q[i])), val_t'(32'h1c00_0000 + 32'(4 * i)));
         if (pop_q.size() >= 4) begin
            check("t2_first_cyc", val_t'(pop_cyc[0]), val_t'(r));
            check("t2_b2b",       val_t'(pop_cyc[3] - pop_cyc[0]), val_t'(3));
         end
         if (iss_q.size() > 4) check("t2_resume", val_t'(iss_q[4]), val_t'(32'h1c00_0010));
      end

      // Branch with two requests in flight
      do_reset();
      mem_hold = 1'b1;
      repeat (3) tick();
      check("t3_outst",  val_t'(mem_q.size()), val_t'(2));
      check("t3_maxout", val_t'(max_out),      val_t'(2));
      check("t3_req",    val_t'(s_req),        val_t'(0));
      br_target = 32'h1c00_0100;
      br_taken  = 1'b1;
      tick();
      check("t3_redir_req", val_t'(s_req), val_t'(0));
      br_taken = 1'b0;
      mem_hold = 1'b0;
      pop_q.delete();
      run_pops(1, 20);
      if (pop_q.size() > 0) begin
         check("t3_pc",   val_t'(zpc(pop_q[0])),   val_t'(32'h1c00_0100));
         check("t3_inst", val_t'(zinst(pop_q[0])), val_t'(exp_inst(32'h1c00_0100)));
      end
      if (iss_q.size() > 2) check("t3_iss", val_t'(iss_q[2]), val_t'(32'h1c00_0100));

      // Flush and branch together: flush target wins
      repeat (5) tick();
      flush_target = 32'h1c00_8000;
      br_target    = 32'h1c00_0200;
      flush = 1'b1; br_taken = 1'b1;
      tick();
      check("t4_valid", val_t'(s_valid), val_t'(0));
      check("t4_req",   val_t'(s_req),   val_t'(0));
      flush = 1'b0; br_taken = 1'b0;
      pop_q.delete();
      run_pops(2, 20);
      if (pop_q.size() > 1) begin
         check("t4_pc0", val_t'(zpc(pop_q[0])), val_t'(32'h1c00_8000));
         check("t4_pc1", val_t'(zpc(pop_q[1])), val_t'(32'h1c00_8004));
      end

      // MMU exception at 1c000040
      ex_pc = 32'h1c00_0040;
      ex_en = 1'b1;
      do_reset();
      run_pops(17, 60);
      if (pop_q.size() > 16) begin
         check("t5_prev_pc", val_t'(zpc(pop_q[15])), val_t'(32'h1c00_003c));
         check("t5_ex_zip",  pop_q[16], {32'h0280_0000, 32'h1c00_0040, 1'b1, 6'h3f, 10'b0});
      end
      begin
         int n_iss;
         n_iss = iss_q.size();
         repeat (8) tick();
         check("t5_issued",  val_t'(n_iss),        val_t'(16));
         check("t5_noissue", val_t'(iss_q.size()), val_t'(n_iss));
         check("t5_req",     val_t'(s_req),        val_t'(0));
         check("t5_nopop",   val_t'(pop_q.size()), val_t'(17));
      end
      flush_target = 32'h1c00_0080;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      run_pops(18, 20);
      if (pop_q.size() > 17) begin
         check("t5_flush_pc", val_t'(zpc(pop_q[17])), val_t'(32'h1c00_0080));
         check("t5_flush_ex", val_t'(zex(pop_q[17])), val_t'(0));
      end
      ex_en = 1'b0;

      // Asynchronous reset mid-burst
      do_reset();
      repeat (6) tick();
      #2 resetn = 1'b0;
      #1;
      check("t6_req",   val_t'(inst_sram_req),  val_t'(0));
      check("t6_valid", val_t'(if_to_id_valid), val_t'(0));
      check("t6_zip",   val_t'(if_to_id_zip),   val_t'(0));
      mem_q.delete(); iss_q.delete(); pop_q.delete(); pop_cyc.delete();
      repeat (2) tick();
      resetn = 1'b1;
      run_pops(2, 20);
      if (iss_q.size() > 0) check("t6_iss0", val_t'(iss_q[0]), val_t'(32'h1c00_0000));
      if (pop_q.size() > 1) begin
         check("t6_pc0", val_t'(zpc(pop_q[0])), val_t'(32'h1c00_0000));
         check("t6_pc1", val_t'(zpc(pop_q[1])), val_t'(32'h1c00_0004));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
